// File: rtl/debug_probe_mux.sv
// Registered debug probe selector: manual switch select or timed auto-scan.
// Optional DEBUG_PROBE_CHG_EN adds a same-channel value-change pulse on chg.
module debug_probe_mux #(
    parameter int          WIDTH    = 32,
    parameter int          NCH      = 8,
    parameter int          SELW     = 3,
    parameter int          SCAN_DIV = 50000000,
    parameter logic [31:0] ERR_VAL  = 32'hDEADDEAD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] ch_data,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode_auto,
    input  logic                 step,
    input  logic                 freeze,
    output logic [WIDTH-1:0]     vdata,
    output logic [NCH-1:0]       sel_led,
    output logic [SELW-1:0]      cur_ch,
    output logic                 sel_err
`ifdef DEBUG_PROBE_CHG_EN
    ,
    output logic                 chg
`endif
);

    localparam int TW = $clog2(SCAN_DIV);

    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_n;
    logic             step_q;
    logic             step_rise;
    logic             adv;
    logic [SELW-1:0]  cur_n;
    logic [WIDTH-1:0] vdata_n;
    logic [NCH-1:0]   led_n;
    logic             err_n;

    function automatic logic [WIDTH-1:0] pick(
        input logic [NCH*WIDTH-1:0] d,
        input logic [SELW-1:0]      i
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(i) == k) r = d[k*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    assign step_rise = step & ~step_q;
    assign adv = (int'(timer) == SCAN_DIV - 1) || step_rise;

    always_comb begin
        cur_n   = cur_ch;
        timer_n = timer;
        vdata_n = vdata;
        led_n   = sel_led;
        err_n   = sel_err;
        if (!freeze) begin
            if (!mode_auto) begin
                timer_n = '0;
                cur_n   = sel;
                if (int'(sel) < NCH) begin
                    vdata_n = pick(ch_data, sel);
                    led_n   = NCH'(1) << sel;
                    err_n   = 1'b0;
                end else begin
                    vdata_n = WIDTH'(ERR_VAL);
                    led_n   = '1;
                    err_n   = 1'b1;
                end
            end else begin
                // An out-of-range manual channel restarts the scan at 0.
                if (int'(cur_ch) >= NCH) begin
                    cur_n = '0;
                end else if (adv) begin
                    if (int'(cur_ch) == NCH - 1) cur_n = '0;
                    else cur_n = cur_ch + 1'b1;
                end
                timer_n = adv ? '0 : timer + 1'b1;
                vdata_n = pick(ch_data, cur_n);
                led_n   = NCH'(1) << cur_n;
                err_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vdata   <= '0;
            sel_led <= '0;
            cur_ch  <= '0;
            sel_err <= 1'b0;
            timer   <= '0;
            step_q  <= 1'b0;
        end else begin
            vdata   <= vdata_n;
            sel_led <= led_n;
            cur_ch  <= cur_n;
            sel_err <= err_n;
            timer   <= timer_n;
            step_q  <= step;
        end
    end

`ifdef DEBUG_PROBE_CHG_EN
    // primed masks the first compare after reset release.
    logic primed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chg    <= 1'b0;
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
            chg    <= primed & ~freeze & (vdata_n != vdata) & (cur_n == cur_ch);
        end
    end
`endif

endmodule

// File: tb/tb_debug_probe_mux.sv
// Self-checking bench for debug_probe_mux against a cycle-level reference model.
// Define DEBUG_PROBE_CHG_EN to also exercise the chg output.
module tb_debug_probe_mux;

    localparam int          W    = 32;
    localparam int          N    = 5;
    localparam int          SW   = 3;
    localparam int          DIV  = 4;
    localparam logic [31:0] EVAL = 32'hDEADDEAD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] ch_data = '0;
    logic [SW-1:0]  sel = '0;
    logic           mode_auto = 1'b0;
    logic           step = 1'b0;
    logic           freeze = 1'b0;
    logic [W-1:0]   vdata;
    logic [N-1:0]   sel_led;
    logic [SW-1:0]  cur_ch;
    logic           sel_err;
    logic           chg;

    int checks = 0;
    int errors = 0;

    debug_probe_mux #(
        .WIDTH(W), .NCH(N), .SELW(SW), .SCAN_DIV(DIV), .ERR_VAL(EVAL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .sel(sel),
        .mode_auto(mode_auto), .step(step), .freeze(freeze),
        .vdata(vdata), .sel_led(sel_led), .cur_ch(cur_ch), .sel_err(sel_err)
`ifdef DEBUG_PROBE_CHG_EN
        , .chg(chg)
`endif
    );

`ifndef DEBUG_PROBE_CHG_EN
    assign chg = 1'b0;
`endif

    always #5 clk = ~clk;

    // Reference model: channel index and dwell count as plain integers.
    logic [W-1:0] m_v;
    logic [N-1:0] m_led;
    int           m_ch;
    int           m_cnt;
    logic         m_err;
    logic         m_stepq;
    logic         m_chg;
    logic         m_primed;

    function automatic bit m_adv();
        return (m_cnt == DIV - 1) || (step && !m_stepq);
    endfunction

    function automatic int m_nc();
        if (!mode_auto) return int'(sel);
        if (m_ch >= N) return 0;
        if (m_adv()) return (m_ch + 1) % N;
        return m_ch;
    endfunction

    function automatic logic [W-1:0] m_nv();
        int c;
        c = m_nc();
        if (c >= N) return EVAL;
        return ch_data[c*W +: W];
    endfunction

    function automatic logic [N-1:0] m_nled();
        int c;
        c = m_nc();
        if (c >= N) return {N{1'b1}};
        return N'(1 << c);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_v <= '0; m_led <= '0; m_ch <= 0; m_cnt <= 0;
            m_err <= 1'b0; m_stepq <= 1'b0; m_chg <= 1'b0; m_primed <= 1'b0;
        end else begin
            m_stepq  <= step;
            m_primed <= 1'b1;
            m_chg    <= m_primed && !freeze && (m_nv() != m_v) && (m_nc() == m_ch);
            if (!freeze) begin
                m_ch  <= m_nc();
                m_v   <= m_nv();
                m_led <= m_nled();
                m_err <= m_nc() >= N;
                m_cnt <= (!mode_auto || m_adv()) ? 0 : m_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < N; k++) ch_data[k*W +: W] = $urandom;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; freeze = 1'b0; mode_auto = 1'b0; sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            rand_data();
            tick();
            checks++;
            if ({vdata, sel_led, cur_ch, sel_err} !== 41'd0) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h/%h/%0d/%b req=0", i,
                         vdata, sel_led, cur_ch, sel_err);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_manual();
        mode_auto = 1'b0; freeze = 1'b0;
        rand_data();
        ch_data[2*W +: W] = 32'h1234_5678;
        sel = 3'd2;
        tick();
        checks++;
        if (vdata !== 32'h1234_5678 || sel_led !== 5'h04 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL manual_sel2 got=%h/%h/%b req=12345678/04/0",
                     vdata, sel_led, sel_err);
        end
        for (int i = 0; i < 20; i++) begin
            sel = SW'($urandom_range(0, N - 1));
            rand_data();
            tick();
            checks++;
            if ({vdata, sel_led, cur_ch, sel_err} !== {m_v, m_led, m_ch[2:0], m_err}) begin
                errors++;
                $display("FAIL manual cyc=%0d got=%h/%h/%0d/%b req=%h/%h/%0d/%b", i,
                         vdata, sel_led, cur_ch, sel_err, m_v, m_led, m_ch, m_err);
            end
        end
    endtask

    task automatic test_error();
        mode_auto = 1'b0; freeze = 1'b0;
        sel = 3'd6;
        tick();
        checks++;
        if (vdata !== 32'hDEADDEAD || sel_led !== 5'h1F || sel_err !== 1'b1
            || cur_ch !== 3'd6) begin
            errors++;
            $display("FAIL error_sel6 got=%h/%h/%0d/%b req=deaddead/1f/6/1",
                     vdata, sel_led, cur_ch, sel_err);
        end
        for (int i = 0; i < 8; i++) begin
            sel = SW'($urandom_range(0, 7));
            step = $urandom_range(0, 1) == 1;
            tick();
            checks++;
            if ({vdata, sel_led, cur_ch, sel_err} !== {m_v, m_led, m_ch[2:0], m_err}) begin
                errors++;
                $display("FAIL error cyc=%0d got=%h/%h/%0d/%b req=%h/%h/%0d/%b", i,
                         vdata, sel_led, cur_ch, sel_err, m_v, m_led, m_ch, m_err);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_auto_wrap();
        int exp;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        mode_auto = 1'b0; sel = 3'd0; step = 1'b0; freeze = 1'b0;
        tick();
        mode_auto = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            // Step rise lands on the terminal-count edge 28.
            step = (k == 28 || k == 29);
            rand_data();
            tick();
            exp = (k / DIV) % N;
            checks++;
            if (int'(cur_ch) != exp || vdata !== ch_data[exp*W +: W]) begin
                errors++;
                $display("FAIL auto_wrap edge=%0d got ch=%0d v=%h req ch=%0d v=%h", k,
                         cur_ch, vdata, exp, ch_data[exp*W +: W]);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_freeze();
        logic [W-1:0] hv;
        int           hc;
        mode_auto = 1'b1; freeze = 1'b0; step = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        freeze = 1'b1;
        tick();
        hv = m_v;
        hc = m_ch;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            step = i[1];
            tick();
            checks++;
            if (vdata !== hv || int'(cur_ch) != hc) begin
                errors++;
                $display("FAIL freeze_hold cyc=%0d got=%h/%0d req=%h/%0d", i,
                         vdata, cur_ch, hv, hc);
            end
        end
        freeze = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            tick();
            checks++;
            if ({vdata, sel_led, cur_ch, sel_err} !== {m_v, m_led, m_ch[2:0], m_err}) begin
                errors++;
                $display("FAIL freeze_resume cyc=%0d got=%h/%h/%0d req=%h/%h/%0d", i,
                         vdata, sel_led, cur_ch, m_v, m_led, m_ch);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst_n = $urandom_range(0, 60) != 0;
            if ($urandom_range(0, 15) == 0) mode_auto = ~mode_auto;
            freeze = $urandom_range(0, 5) == 0;
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 7) == 0) sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) rand_data();
            tick();
            checks++;
            if ({vdata, sel_led, cur_ch, sel_err} !== {m_v, m_led, m_ch[2:0], m_err}) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h/%h/%0d/%b req=%h/%h/%0d/%b", i,
                         vdata, sel_led, cur_ch, sel_err, m_v, m_led, m_ch, m_err);
            end
`ifdef DEBUG_PROBE_CHG_EN
            checks++;
            if (chg !== m_chg) begin
                errors++;
                $display("FAIL random_chg cyc=%0d got=%b req=%b", i, chg, m_chg);
            end
`endif
        end
        rst_n = 1'b1; freeze = 1'b0; step = 1'b0;
    endtask

`ifdef DEBUG_PROBE_CHG_EN
    task automatic test_chg();
        mode_auto = 1'b0; freeze = 1'b0; sel = 3'd1;
        ch_data = '0;
        ch_data[1*W +: W] = 32'd5;
        ch_data[2*W +: W] = 32'd77;
        tick(); tick();
        ch_data[1*W +: W] = 32'd9;
        tick();
        checks++;
        if (chg !== 1'b1 || vdata !== 32'd9) begin
            errors++;
            $display("FAIL chg_pulse got chg=%b v=%0d req chg=1 v=9", chg, vdata);
        end
        tick();
        checks++;
        if (chg !== 1'b0) begin
            errors++;
            $display("FAIL chg_one_clk got=%b req=0", chg);
        end
        sel = 3'd2;
        tick();
        checks++;
        if (chg !== 1'b0 || vdata !== 32'd77) begin
            errors++;
            $display("FAIL chg_chan_switch got chg=%b v=%0d req chg=0 v=77", chg, vdata);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_manual();
        test_error();
        test_auto_wrap();
        test_freeze();
`ifdef DEBUG_PROBE_CHG_EN
        test_chg();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
